// File: rtl/pn_pkg.sv
// Shared definitions for the processing-node spike packet format.
// The same field positions are used by the PN controller decoder.
package pn_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;
    localparam int ID_W   = 7;

    localparam int PARAM_BIT = 15;
    localparam int RC_BIT    = 14;
    localparam int ID2_MSB   = 13;
    localparam int ID2_LSB   = 7;
    localparam int ID1_MSB   = 6;
    localparam int ID1_LSB   = 0;

    localparam logic [ID_W-1:0] NULL_ID = 7'd0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } enc_state_e;

    // Spike address word; the encoder never emits parameter packets.
    function automatic logic [ADDR_W-1:0] pack_addr(input logic            rc,
                                                    input logic [ID_W-1:0] id2,
                                                    input logic [ID_W-1:0] id1);
        logic [ADDR_W-1:0] a;
        a                   = '0;
        a[PARAM_BIT]        = 1'b0;
        a[RC_BIT]           = rc;
        a[ID2_MSB:ID2_LSB]  = id2;
        a[ID1_MSB:ID1_LSB]  = id1;
        return a;
    endfunction

endpackage

// File: rtl/spike_packet_encoder_if.sv
// Spike-in / flush / packet-out signal bundle of the spike packet encoder.
// slave = the encoder itself, master = soma array, timestep control and packet path.
interface spike_packet_encoder_if;
    import pn_pkg::*;

    logic              fire_valid;
    logic [ID_W-1:0]   fire_id;
    logic              fire_rc;
    logic              fire_ready;
    logic              flush_req;
    logic              flush_done;
    logic              pkt_valid;
    logic [ADDR_W-1:0] pkt_addr;
    logic [DATA_W-1:0] pkt_data;
    logic              pkt_ready;
    logic              drop_err;

    modport master (
        output fire_valid, fire_id, fire_rc, flush_req, pkt_ready,
        input  fire_ready, flush_done, pkt_valid, pkt_addr, pkt_data, drop_err
    );

    modport slave (
        input  fire_valid, fire_id, fire_rc, flush_req, pkt_ready,
        output fire_ready, flush_done, pkt_valid, pkt_addr, pkt_data, drop_err
    );

endinterface

// File: rtl/pn_pkt_reg.sv
// One-entry valid/ready output register: load, hold while stalled, drain.
// The caller only loads when slot_free_o is high, so a load may coincide with a drain.
module pn_pkt_reg #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  ready_i,
    output logic                  valid_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  slot_free_o
);

    logic                  valid_q, valid_d;
    logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
    logic [DATA_WIDTH-1:0] data_q,  data_d;

    // Next-state: new word on load, otherwise hold, dropping valid once taken.
    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            addr_d  = addr_i;
            data_d  = data_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    // Register stage with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign valid_o     = valid_q;
    assign addr_o      = addr_q;
    assign data_o      = data_q;
    assign slot_free_o = !valid_q || ready_i;

endmodule

// File: rtl/spike_packet_encoder.sv
// Packs fired neuron IDs into spike packets: pairs of plain spikes or single
// Rich-Club spikes, stamped with the current timestep.
//
// state | meaning
// IDLE  | nothing held
// HOLD  | one plain ID waiting for a partner in hold_id
// FLUSH | timestep ending, emitting the held single
// DONE  | pulse flush_done, advance timestep
module spike_packet_encoder
    import pn_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input logic                   clk,
    input logic                   rst,
    spike_packet_encoder_if.slave bus
);

    enc_state_e        state_q, state_d;
    logic [ID_W-1:0]   hold_id_q, hold_id_d;
    logic [DATA_W-1:0] timestep_q, timestep_d;
    logic              drop_err_q, drop_err_d;
    logic              flush_done_q, flush_done_d;
    logic              armed_q, armed_d;

    logic              slot_free;
    logic              accepting;
    logic              fire_ready;
    logic              fire_acc;
    logic              flush_take;
    logic              load;
    logic [ADDR_W-1:0] load_addr;

    assign accepting  = (state_q == IDLE) || (state_q == HOLD);
    assign fire_ready = slot_free && !bus.flush_req && accepting;
    assign fire_acc   = bus.fire_valid && fire_ready;
    // A flush is only taken once flush_req has been low since the last one.
    assign flush_take = bus.flush_req && armed_q && accepting;

    // Next-state, pairing and packet load decisions.
    always_comb begin
        state_d      = state_q;
        hold_id_d    = hold_id_q;
        timestep_d   = timestep_q;
        drop_err_d   = drop_err_q;
        flush_done_d = 1'b0;
        armed_d      = armed_q || !bus.flush_req;
        load         = 1'b0;
        load_addr    = '0;
        unique case (state_q)
            IDLE, HOLD: begin
                if (flush_take) begin
                    armed_d = 1'b0;
                    state_d = (state_q == HOLD) ? FLUSH : DONE;
                end else if (fire_acc) begin
                    if (bus.fire_id == NULL_ID) begin
                        drop_err_d = 1'b1;
                    end else if (bus.fire_rc) begin
                        // Rich-Club spikes bypass whatever is held.
                        load      = 1'b1;
                        load_addr = pack_addr(1'b1, NULL_ID, bus.fire_id);
                    end else if (state_q == IDLE) begin
                        hold_id_d = bus.fire_id;
                        state_d   = HOLD;
                    end else begin
                        load      = 1'b1;
                        load_addr = pack_addr(1'b0, bus.fire_id, hold_id_q);
                        hold_id_d = NULL_ID;
                        state_d   = IDLE;
                    end
                end
            end
            FLUSH: begin
                if (slot_free) begin
                    load      = 1'b1;
                    load_addr = pack_addr(1'b0, NULL_ID, hold_id_q);
                    hold_id_d = NULL_ID;
                    state_d   = DONE;
                end
            end
            DONE: begin
                flush_done_d = 1'b1;
                timestep_d   = timestep_q + 32'd1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            hold_id_q    <= NULL_ID;
            timestep_q   <= '0;
            drop_err_q   <= 1'b0;
            flush_done_q <= 1'b0;
            armed_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            hold_id_q    <= hold_id_d;
            timestep_q   <= timestep_d;
            drop_err_q   <= drop_err_d;
            flush_done_q <= flush_done_d;
            armed_q      <= armed_d;
        end
    end

    pn_pkt_reg #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_pkt_reg (
        .clk         (clk),
        .rst         (rst),
        .load_i      (load),
        .addr_i      (load_addr),
        .data_i      (timestep_q),
        .ready_i     (bus.pkt_ready),
        .valid_o     (bus.pkt_valid),
        .addr_o      (bus.pkt_addr),
        .data_o      (bus.pkt_data),
        .slot_free_o (slot_free)
    );

    assign bus.fire_ready = fire_ready;
    assign bus.flush_done = flush_done_q;
    assign bus.drop_err   = drop_err_q;

endmodule

// File: tb/tb_spike_packet_encoder.sv
// Bench for spike_packet_encoder: spike-level reference model feeding an
// expected-packet queue, with an independent output monitor.
module tb_spike_packet_encoder;

    logic clk;
    logic rst;

    spike_packet_encoder_if bus();

    spike_packet_encoder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;

    // Reference model: held plain ID (0 = none), timestep, sticky drop flag.
    logic [6:0]  m_held;
    logic [31:0] m_ts;
    bit          m_drop;
    logic [47:0] exp_q[$];
    bit          expect_valid;

    bit          stall_pend;
    logic [15:0] st_addr;
    logic [31:0] st_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every taken packet with the head of the queue and
    // checks that a stalled packet stays put.
    initial begin
        stall_pend = 0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                stall_pend = 0;
            end else begin
                if (stall_pend) begin
                    chk("stall_addr", {16'h0, bus.pkt_addr}, {16'h0, st_addr});
                    chk("stall_data", bus.pkt_data, st_data);
                    chk("stall_valid", {31'h0, bus.pkt_valid}, 32'h1);
                end
                stall_pend = 0;
                if (bus.pkt_valid && bus.pkt_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errs++;
                        $display("FAIL unexpected_pkt: got addr 0x%0h data 0x%0h expected no packet",
                                 bus.pkt_addr, bus.pkt_data);
                    end else begin
                        logic [47:0] e;
                        e = exp_q.pop_front();
                        chk("pkt_addr", {16'h0, bus.pkt_addr}, {16'h0, e[47:32]});
                        chk("pkt_data", bus.pkt_data, e[31:0]);
                    end
                end else if (bus.pkt_valid) begin
                    stall_pend = 1;
                    st_addr    = bus.pkt_addr;
                    st_data    = bus.pkt_data;
                end
            end
        end
    end

    task automatic model_accept(input logic [6:0] id, input bit rc);
        if (id == 7'd0) begin
            m_drop = 1;
        end else if (rc) begin
            exp_q.push_back({16'h4000 | {9'd0, id}, m_ts});
            expect_valid = 1;
        end else if (m_held == 7'd0) begin
            m_held = id;
        end else begin
            exp_q.push_back({2'b00, id, m_held, m_ts});
            m_held       = 7'd0;
            expect_valid = 1;
        end
    endtask

    task automatic pre_checks();
        if (expect_valid) chk("latency_valid", {31'h0, bus.pkt_valid}, 32'h1);
        chk("drop_err", {31'h0, bus.drop_err}, {31'h0, m_drop});
        chk("no_flush_done", {31'h0, bus.flush_done}, 32'h0);
        expect_valid = 0;
    endtask

    task automatic step(input bit fv, input logic [6:0] id, input bit rc, input bit rdy);
        bit exp_fr;
        @(negedge clk);
        pre_checks();
        bus.fire_valid = fv;
        bus.fire_id    = id;
        bus.fire_rc    = rc;
        bus.pkt_ready  = rdy;
        #1;
        exp_fr = !bus.pkt_valid || rdy;
        chk("fire_ready", {31'h0, bus.fire_ready}, {31'h0, exp_fr});
        if (fv && bus.fire_ready) model_accept(id, rc);
    endtask

    task automatic do_flush(input bit rand_rdy);
        bit had_held;
        bit got;
        int lat;
        @(negedge clk);
        pre_checks();
        bus.fire_valid = 1'b1;
        bus.fire_id    = 7'($urandom_range(1, 127));
        bus.fire_rc    = 1'($urandom);
        bus.flush_req  = 1'b1;
        bus.pkt_ready  = rand_rdy ? 1'($urandom) : 1'b1;
        #1;
        chk("fire_ready_flush", {31'h0, bus.fire_ready}, 32'h0);
        had_held = (m_held != 7'd0);
        if (had_held) exp_q.push_back({16'h0 | {9'd0, m_held}, m_ts});
        m_held = 7'd0;
        got = 0;
        lat = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            bus.pkt_ready = rand_rdy ? 1'($urandom) : 1'b1;
            #2;
            if (bus.flush_done) begin
                got = 1;
                lat = i;
            end
        end
        chk("flush_done_seen", {31'h0, got}, 32'h1);
        if (!rand_rdy && got) chk("flush_latency", lat, had_held ? 32'd2 : 32'd1);
        m_ts = m_ts + 32'd1;
        // flush_req still held: pulse must end and no second flush may start.
        repeat (2) begin
            @(negedge clk);
            bus.fire_valid = 1'b0;
            #1;
            chk("flush_done_pulse", {31'h0, bus.flush_done}, 32'h0);
        end
        @(negedge clk);
        bus.flush_req = 1'b0;
        #1;
        chk("flush_done_rearm", {31'h0, bus.flush_done}, 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst            = 1'b1;
        bus.pkt_ready  = 1'b0;
        bus.fire_valid = 1'b0;
        bus.flush_req  = 1'b0;
        exp_q.delete();
        m_held       = 7'd0;
        m_ts         = 32'd0;
        m_drop       = 0;
        expect_valid = 0;
        @(negedge clk);
        #1;
        chk("rst_pkt_valid", {31'h0, bus.pkt_valid}, 32'h0);
        chk("rst_pkt_addr", {16'h0, bus.pkt_addr}, 32'h0);
        chk("rst_pkt_data", bus.pkt_data, 32'h0);
        chk("rst_flush_done", {31'h0, bus.flush_done}, 32'h0);
        chk("rst_drop_err", {31'h0, bus.drop_err}, 32'h0);
        rst = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    initial begin
        rst            = 1'b1;
        bus.fire_valid = 1'b0;
        bus.fire_id    = 7'd0;
        bus.fire_rc    = 1'b0;
        bus.flush_req  = 1'b0;
        bus.pkt_ready  = 1'b0;
        m_held         = 7'd0;
        m_ts           = 32'd0;
        m_drop         = 0;
        expect_valid   = 0;
        repeat (3) @(negedge clk);
        do_reset();

        // Pair 5,9 -> 0x0485 stamped 0.
        step(1, 7'd5, 0, 1);
        step(1, 7'd9, 0, 1);
        step(0, 7'd0, 0, 1);
        step(0, 7'd0, 0, 1);

        // Held 3 is overtaken by RC 12: 0x400C then 0x0383.
        step(1, 7'd3, 0, 1);
        step(1, 7'd12, 1, 1);
        step(1, 7'd7, 0, 1);
        step(0, 7'd0, 0, 1);

        // Single 17 drained by a flush, next packet stamped 1.
        step(1, 7'd17, 0, 1);
        do_flush(0);
        step(1, 7'd1, 0, 1);
        step(1, 7'd2, 0, 1);
        step(0, 7'd0, 0, 1);

        // Pair pending under four cycles of back-pressure.
        step(1, 7'd30, 0, 0);
        step(1, 7'd31, 0, 0);
        repeat (4) step(1, 7'd40, 0, 0);
        step(0, 7'd0, 0, 1);
        step(0, 7'd0, 0, 1);

        // Null ID is dropped and sticks; reset while holding discards the spike.
        step(1, 7'd0, 0, 1);
        repeat (3) step(0, 7'd0, 0, 1);
        step(1, 7'd17, 0, 1);
        step(0, 7'd0, 0, 1);
        do_reset();
        do_flush(0);
        step(0, 7'd0, 0, 1);

        // Randomised traffic with occasional flushes.
        for (int n = 0; n < 400; n++) begin
            if ((n % 47) == 46) begin
                do_flush(1);
            end else begin
                logic [6:0] rid;
                rid = (($urandom % 20) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
                step(1'($urandom_range(0, 3) != 0), rid, ($urandom % 4) == 0,
                     ($urandom % 10) < 7);
            end
        end
        repeat (4) step(0, 7'd0, 0, 1);

        // Timestep wrap: preload all-ones, one flush returns it to zero.
        do_reset();
        @(negedge clk);
        force dut.timestep_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.timestep_q;
        m_ts = 32'hFFFF_FFFF;
        step(1, 7'd20, 0, 1);
        step(1, 7'd21, 0, 1);
        step(1, 7'd22, 0, 1);
        do_flush(0);
        step(1, 7'd1, 0, 1);
        step(1, 7'd2, 0, 1);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step(0, 7'd0, 0, 1);
        step(0, 7'd0, 0, 1);
        chk("queue_empty", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
